// File: rtl/bitwise_pkg.sv
// Shared op encoding and the per-bit op evaluator for the bitwise pipe.
package bitwise_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  // Single-bit evaluator; the top replicates it across every bit lane since
  // all ops are carry-free.
  function automatic logic apply_op(input op_e op, input logic a, input logic b);
    logic r;
    case (op)
      OP_NOT:  r = ~a;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NAND: r = ~(a & b);
      OP_NOR:  r = ~(a | b);
      OP_XNOR: r = ~(a ^ b);
      OP_PASS: r = a;
      default: r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bitwise_pipe_n_pipe_stage.sv
// One elastic pipeline slot: valid + data register with load enable and
// async clear. Data only captures when a valid item arrives so idle
// operand wiggle never toggles the data flops.
module pipe_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_en,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] dat_o
);

  logic             vld_d, vld_q;
  logic [WIDTH-1:0] dat_d, dat_q;

  // Next state: take upstream valid on load, capture data only with a valid item.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (ld_en) begin
      vld_d = vld_i;
      if (vld_i) dat_d = dat_i;
    end
  end

  // Slot registers, cleared asynchronously so in-flight items are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign dat_o = dat_q;

endmodule

// File: rtl/bitwise_pipe_n.sv
// Pipelined bitwise logic unit: op evaluated at the input, result carried
// through STAGES elastic slots under valid/ready, handoffs counted.
module bitwise_pipe_n
  import bitwise_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  // Index 0 is the input side, index STAGES is the output slot.
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0]            rdy;
  logic [STAGES:0][WIDTH-1:0] dat_pipe;

  op_e              op;
  logic [WIDTH-1:0] res;

  assign op = op_e'(in_op);

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign res[g] = apply_op(op, in_a[g], in_b[g]);
  end

  assign vld_pipe[0] = in_valid;
  assign dat_pipe[0] = res;

  // Ready chain: a slot can take new data if it is empty or everything
  // downstream of it can move. Accumulated walking back from the output so
  // no signal reads itself.
  always_comb begin
    logic acc;
    acc         = out_ready;
    rdy         = '0;
    rdy[STAGES] = acc;
    for (int i = STAGES; i >= 1; i--) begin
      acc      = acc | ~vld_pipe[i];
      rdy[i-1] = acc;
    end
  end

  for (genvar s = 1; s <= STAGES; s++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .ld_en (rdy[s-1]),
      .vld_i (vld_pipe[s-1]),
      .dat_i (dat_pipe[s-1]),
      .vld_o (vld_pipe[s]),
      .dat_o (dat_pipe[s])
    );
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld_pipe[STAGES];
  assign out_data  = dat_pipe[STAGES];

  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Count handoffs; wraps silently at the counter width.
  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready) cnt_d = cnt_q + 1'b1;
  end

  // Handoff counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;

endmodule

// File: tb/tb_bitwise_pipe_n.sv
// Directed bench for bitwise_pipe_n (WIDTH=16, STAGES=2) plus a 4-bit
// counter instance sharing the same stimulus for the wrap case.
module tb_bitwise_pipe_n;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [2:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_data;
  logic [15:0]   out_count;
  logic          in_ready_w, out_valid_w;
  logic [W-1:0]  out_data_w;
  logic [3:0]    out_count_w;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  bitwise_pipe_n #(.WIDTH(W), .STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
  );

  bitwise_pipe_n #(.WIDTH(W), .STAGES(2), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .out_valid(out_valid_w),
    .out_ready(out_ready), .out_data(out_data_w), .out_count(out_count_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent reference for the random phase.
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~(a & b);
      3'd5:    return ~(a | b);
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  logic [W-1:0] op_exp [8] = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0,
                               16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
  logic [W-1:0] q [$];
  logic [W-1:0] expv;
  logic [W-1:0] prev_data;
  logic         prev_stall;

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; in_op = 3'd0; in_a = '0; in_b = '0;

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data",  64'(out_data),  64'(0));
    check("rst_out_count", 64'(out_count), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    step();
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // All eight ops, latency of two cycles each
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_op = k[2:0]; in_a = 16'hF0F0; in_b = 16'hFF00; out_ready = 1'b1;
      #1;
      check("op_in_ready", 64'(in_ready), 64'(1));
      step();
      in_valid = 1'b0; in_a = '0; in_b = '0;
      check("op_lat1_valid", 64'(out_valid), 64'(0));
      step();
      check("op_valid", 64'(out_valid), 64'(1));
      check("op_data", 64'(out_data), 64'(op_exp[k]));
      step();
      check("op_drained", 64'(out_valid), 64'(0));
    end
    exp_cnt = 8;
    check("op_count", 64'(out_count), 64'(exp_cnt));

    // Walking-one NOT, back to back
    in_op = 3'd0; in_b = 16'hAAAA; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_a = 16'h0001 << i;
      #1;
      check("walk_in_ready", 64'(in_ready), 64'(1));
      step();
      if (i > 0) begin
        expv = ~(16'h0001 << (i - 1));
        check("walk_valid", 64'(out_valid), 64'(1));
        check("walk_data", 64'(out_data), 64'(expv));
      end
    end
    in_valid = 1'b0;
    step();
    check("walk_last", 64'(out_data), 64'(16'h7FFF));
    step();
    check("walk_drained", 64'(out_valid), 64'(0));
    exp_cnt = 24;
    check("walk_count", 64'(out_count), 64'(exp_cnt));

    // Backpressure: AND, OR, NOR, XNOR of 1234/0F0F
    out_ready = 1'b0; in_valid = 1'b1; in_a = 16'h1234; in_b = 16'h0F0F; in_op = 3'd1;
    step();
    check("bp_ready_after1", 64'(in_ready), 64'(1));
    in_op = 3'd2;
    step();
    check("bp_ready_full", 64'(in_ready), 64'(0));
    check("bp_valid", 64'(out_valid), 64'(1));
    check("bp_data0", 64'(out_data), 64'(16'h0204));
    in_op = 3'd5;
    step();
    step();
    check("bp_hold_valid", 64'(out_valid), 64'(1));
    check("bp_hold_data", 64'(out_data), 64'(16'h0204));
    check("bp_hold_ready", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 64'(in_ready), 64'(1));
    step();
    in_op = 3'd6;
    check("bp_data1", 64'(out_data), 64'(16'h1F3F));
    step();
    in_valid = 1'b0;
    check("bp_data2", 64'(out_data), 64'(16'hE0C0));
    step();
    check("bp_data3", 64'(out_data), 64'(16'hE2C4));
    step();
    check("bp_drained", 64'(out_valid), 64'(0));
    exp_cnt = 28;
    check("bp_count", 64'(out_count), 64'(exp_cnt));

    // Random valid/ready against the scoreboard
    prev_stall = 1'b0; prev_data = '0;
    for (int n = 0; n < 600; n++) begin
      if (prev_stall) begin
        check("rnd_stall_valid", 64'(out_valid), 64'(1));
        check("rnd_stall_data", 64'(out_data), 64'(prev_data));
      end
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      in_op = 3'($urandom); in_a = 16'($urandom); in_b = 16'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("rnd_spurious", 64'(1), 64'(0));
        else begin
          expv = q.pop_front();
          check("rnd_data", 64'(out_data), 64'(expv));
          exp_cnt++;
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b));
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) check("rnd_spurious", 64'(1), 64'(0));
        else begin
          expv = q.pop_front();
          check("rnd_data", 64'(out_data), 64'(expv));
          exp_cnt++;
        end
      end
      step();
    end
    check("rnd_drained", 64'(q.size()), 64'(0));
    check("rnd_count", 64'(out_count), 64'(exp_cnt & 16'hFFFF));
    check("rnd_count_w", 64'(out_count_w), 64'(exp_cnt & 15));

    // Mid-stream async reset, checked before any clock edge
    out_ready = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_a = 16'h00FF;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 64'(out_valid), 64'(0));
    check("mrst_out_data",  64'(out_data),  64'(0));
    check("mrst_out_count", 64'(out_count), 64'(0));
    check("mrst_count_w",   64'(out_count_w), 64'(0));
    check("mrst_in_ready",  64'(in_ready), 64'(1));
    in_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    step();

    // 17 handoffs: 16-bit counter reads 17, 4-bit counter wraps to 1
    out_ready = 1'b1; in_valid = 1'b1; in_op = 3'd7;
    for (int i = 0; i < 17; i++) begin
      in_a = 16'(i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("wrap_last", 64'(out_data), 64'(16));
    step();
    check("wrap_drained", 64'(out_valid), 64'(0));
    check("wrap_count", 64'(out_count), 64'(17));
    check("wrap_count_w", 64'(out_count_w), 64'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
